// File: rtl/tiny_nn_pkg.sv
// Shared types for the tiny_nn MAC array and its command sequencer.
package tiny_nn_pkg;

  // Unsigned Q8.8 fixed point, the word format of the array datapath.
  typedef logic [15:0] fp_t;

  typedef enum logic {
    CMD_LOAD_PARAM = 1'b0,
    CMD_RUN        = 1'b1
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PARAM,
    LOAD_VAL,
    MUL_A,
    MUL_B,
    ACC,
    RESP
  } ctrl_state_e;

  localparam int unsigned AccStages = 3;

endpackage

// File: rtl/tiny_nn_core_ctrl_if.sv
// Host-side command, data and result handshakes of tiny_nn_core_ctrl.
interface tiny_nn_core_ctrl_if;
  import tiny_nn_pkg::*;

  logic    cmd_valid;
  logic    cmd_ready;
  cmd_op_e cmd_op;
  logic    data_valid;
  logic    data_ready;
  fp_t     data;
  logic    result_valid;
  logic    result_ready;
  fp_t     result;

  modport master (
    output cmd_valid, cmd_op, data_valid, data, result_ready,
    input  cmd_ready, data_ready, result_valid, result
  );

  modport slave (
    input  cmd_valid, cmd_op, data_valid, data, result_ready,
    output cmd_ready, data_ready, result_valid, result
  );

endinterface

// File: rtl/tiny_nn_core_ctrl.sv
// Sequencer turning LOAD_PARAM / RUN commands plus a shared data stream into
// the strobes of one 4x2 tiny_nn_core, and handing back its dot-product.
module tiny_nn_core_ctrl
  import tiny_nn_pkg::*;
#(
  parameter int unsigned ValArrayWidth  = 4,
  parameter int unsigned ValArrayHeight = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  tiny_nn_core_ctrl_if.slave                      host,
  output logic                                    busy_o,
  output logic                                    params_loaded_o,
  output fp_t                                     val_o,
  output logic [ValArrayHeight-1:0]               val_shift_o,
  output fp_t                                     param_o,
  output logic [ValArrayWidth*ValArrayHeight-1:0] param_write_o,
  output logic                                    mul_row_sel_o,
  output logic                                    mul_en_o,
  output logic                                    accumulate_en_o,
  input  fp_t                                     accumulate_i
);

  localparam int unsigned NumParams = ValArrayWidth * ValArrayHeight;
  localparam int unsigned BeatW     = $clog2(NumParams);
  localparam int unsigned ColBits   = $clog2(ValArrayWidth);
  localparam int unsigned RowBits   = $clog2(ValArrayHeight);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumParams - 1);
  localparam logic [1:0]       AccLast  = 2'(AccStages - 1);

  if (ValArrayWidth != 4) begin : g_width_check
    $error("tiny_nn_core_ctrl supports ValArrayWidth = 4 only");
  end
  if (ValArrayHeight != 2) begin : g_height_check
    $error("tiny_nn_core_ctrl supports ValArrayHeight = 2 only");
  end

  ctrl_state_e        state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [1:0]         acc_cnt_q, acc_cnt_d;
  logic               loaded_q, loaded_d;
  logic [RowBits-1:0] beat_row;

  // Beats fill row 0 first, then row 1, ValArrayWidth beats per row.
  assign beat_row = beat_q[ColBits +: RowBits];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      acc_cnt_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      acc_cnt_q <= acc_cnt_d;
      loaded_q  <= loaded_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    acc_cnt_d         = acc_cnt_q;
    loaded_d          = loaded_q;
    host.cmd_ready    = 1'b0;
    host.data_ready   = 1'b0;
    host.result_valid = 1'b0;
    val_shift_o       = '0;
    param_write_o     = '0;
    mul_row_sel_o     = 1'b0;
    mul_en_o          = 1'b0;
    accumulate_en_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        host.cmd_ready = 1'b1;
        if (host.cmd_valid) begin
          beat_d  = '0;
          state_d = (host.cmd_op == CMD_RUN) ? LOAD_VAL : LOAD_PARAM;
        end
      end
      LOAD_PARAM: begin
        host.data_ready = 1'b1;
        if (host.data_valid) begin
          param_write_o[beat_q] = 1'b1;
          if (beat_q == LastBeat) begin
            loaded_d = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      LOAD_VAL: begin
        host.data_ready = 1'b1;
        if (host.data_valid) begin
          val_shift_o[beat_row] = 1'b1;
          if (beat_q == LastBeat) begin
            state_d = MUL_A;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      MUL_A: begin
        mul_en_o      = 1'b1;
        mul_row_sel_o = 1'b1;
        state_d       = MUL_B;
      end
      MUL_B: begin
        mul_en_o  = 1'b1;
        acc_cnt_d = '0;
        state_d   = ACC;
      end
      ACC: begin
        accumulate_en_o = 1'b1;
        if (acc_cnt_q == AccLast) begin
          acc_cnt_d = '0;
          state_d   = RESP;
        end else begin
          acc_cnt_d = acc_cnt_q + 1'b1;
        end
      end
      RESP: begin
        host.result_valid = 1'b1;
        if (host.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o          = (state_q != IDLE);
  assign params_loaded_o = loaded_q;
  assign val_o           = host.data;
  assign param_o         = host.data;
  // Core holds its accumulator while accumulate_en_o is low, so RESP sees a stable value.
  assign host.result     = accumulate_i;

endmodule

// File: tb/tb_tiny_nn_core_ctrl.sv
// Scoreboard bench for tiny_nn_core_ctrl with a behavioural 4x2 core model.
module tb_tiny_nn_core_ctrl;
  import tiny_nn_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       busy, params_loaded;
  fp_t        val, param, accumulate;
  logic [1:0] val_shift;
  logic [7:0] param_write;
  logic       mul_row_sel, mul_en, acc_en;

  tiny_nn_core_ctrl_if bus ();

  tiny_nn_core_ctrl #(.ValArrayWidth(4), .ValArrayHeight(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .host           (bus),
    .busy_o         (busy),
    .params_loaded_o(params_loaded),
    .val_o          (val),
    .val_shift_o    (val_shift),
    .param_o        (param),
    .param_write_o  (param_write),
    .mul_row_sel_o  (mul_row_sel),
    .mul_en_o       (mul_en),
    .accumulate_en_o(acc_en),
    .accumulate_i   (accumulate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  fp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic fp_t fp(input real r);
    return fp_t'(int'(r * 256.0));
  endfunction

  // Behavioural core: param regs, per-row value shifters, 8 product slots reduced by a 3-stage tree.
  fp_t cm_param[8];
  fp_t cm_val[2][4];
  fp_t cm_s[8];

  function automatic fp_t fmul(input fp_t a, input fp_t b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[23:8];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) if (param_write[k]) cm_param[k] <= param;
    for (int r = 0; r < 2; r++) begin
      if (val_shift[r]) begin
        for (int c = 0; c < 3; c++) cm_val[r][c] <= cm_val[r][c+1];
        cm_val[r][3] <= val;
      end
    end
    if (mul_en) begin
      for (int c = 0; c < 4; c++)
        cm_s[int'(mul_row_sel)*4 + c] <= fmul(cm_param[int'(mul_row_sel)*4 + c], cm_val[int'(mul_row_sel)][c]);
    end
    if (acc_en) begin
      for (int i = 0; i < 4; i++) cm_s[i] <= cm_s[2*i] + cm_s[2*i+1];
      for (int i = 4; i < 8; i++) cm_s[i] <= '0;
    end
  end
  assign accumulate = cm_s[0];

  always @(posedge clk) cyc++;

  // Monitor: strobe ordering, latency, pulse counts and scoreboard pops.
  int pw_cnt = 0, vs_cnt = 0, mul_cnt = 0, acc_cnt = 0, vs_last_cyc = 0;
  logic rv_prev = 1'b0;
  fp_t exp_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      pw_cnt = 0; vs_cnt = 0; mul_cnt = 0; acc_cnt = 0; rv_prev = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        pw_cnt = 0; vs_cnt = 0;
      end
      if (param_write != 8'h00) begin
        check("param_write_onehot", 32'(param_write), 32'(8'h01 << pw_cnt));
        check("param_write_hs", 32'(bus.data_valid && bus.data_ready), 32'd1);
        pw_cnt++;
      end
      if (val_shift != 2'b00) begin
        check("val_shift_row", 32'(val_shift), (vs_cnt < 4) ? 32'd1 : 32'd2);
        check("val_shift_hs", 32'(bus.data_valid && bus.data_ready), 32'd1);
        if (vs_cnt == 7) vs_last_cyc = cyc;
        vs_cnt++;
      end
      if (mul_en) begin
        check("mul_row_sel", 32'(mul_row_sel), (mul_cnt == 0) ? 32'd1 : 32'd0);
        mul_cnt++;
      end
      if (acc_en) acc_cnt++;
      if (bus.result_valid && !rv_prev) begin
        check("result_latency", 32'(cyc - vs_last_cyc), 32'd6);
        check("mul_en_cycles", 32'(mul_cnt), 32'd2);
        check("acc_en_cycles", 32'(acc_cnt), 32'd3);
        mul_cnt = 0; acc_cnt = 0;
      end
      if (bus.result_valid && bus.result_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_r = exp_q.pop_front();
          check("result", 32'(bus.result), 32'(exp_r));
        end
      end
      rv_prev = bus.result_valid;
    end
  end

  fp_t p_ones[8], p_set2[8], v_seq[8], v_set2[8];

  task automatic send_cmd(input cmd_op_e op);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 100);
    if (!bus.cmd_ready) check("cmd_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input fp_t d, input int gap);
    int n = 0;
    bus.data_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.data_valid = 1'b1;
    bus.data       = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.data_ready && n < 100);
    if (!bus.data_ready) check("data_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("result_timeout", 32'd1, 32'd0);
  endtask

  task automatic load(input fp_t p[8], input bit gaps, input bit check_partial);
    send_cmd(CMD_LOAD_PARAM);
    for (int i = 0; i < 8; i++) begin
      send_beat(p[i], gaps ? int'($urandom_range(1, 3)) : 0);
      if (check_partial && i == 4) check("loaded_after_5", 32'(params_loaded), 32'd0);
    end
    check("loaded_after_8", 32'(params_loaded), 32'd1);
    check("param_beats", 32'(pw_cnt), 32'd8);
    check("load_idle", 32'(busy), 32'd0);
  endtask

  task automatic run(input fp_t v[8], input bit gaps, input bit hold, input real exp);
    int n = 0;
    send_cmd(CMD_RUN);
    if (hold) bus.result_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(v[i], gaps ? int'($urandom_range(1, 3)) : 0);
    exp_q.push_back(fp(exp));
    if (hold) begin
      while (!bus.result_valid && n < 60) begin @(negedge clk); n++; end
      if (!bus.result_valid) check("resp_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = CMD_LOAD_PARAM;
      bus.data_valid = 1'b1;
      bus.data       = fp(9.0);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check("hold_valid", 32'(bus.result_valid), 32'd1);
        check("hold_result", 32'(bus.result), 32'(fp(exp)));
        check("hold_ready", {30'd0, bus.cmd_ready, bus.data_ready}, 32'd0);
        check("hold_strobes", {20'd0, param_write, val_shift, mul_en, acc_en}, 32'd0);
      end
      @(posedge clk); #1;
      bus.cmd_valid    = 1'b0;
      bus.data_valid   = 1'b0;
      bus.result_ready = 1'b1;
    end
    wait_drain();
    check("val_beats", 32'(vs_cnt), 32'd8);
    check("loaded_after_run", 32'(params_loaded), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_loaded"}, 32'(params_loaded), 32'd0);
    check({tag, "_ready"}, {30'd0, bus.cmd_ready, bus.data_ready}, 32'd2);
    check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_strobes"}, {19'd0, param_write, val_shift, mul_row_sel, mul_en, acc_en}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      p_ones[i] = fp(1.0);
      v_seq[i]  = fp(real'(i + 1));
    end
    p_set2 = '{fp(0.5), fp(1.0), fp(2.0), fp(0.0), fp(1.0), fp(1.0), fp(1.0), fp(1.0)};
    v_set2 = '{fp(2.0), fp(2.0), fp(2.0), fp(2.0), fp(3.0), fp(0.0), fp(1.0), fp(1.0)};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = CMD_LOAD_PARAM;
    bus.data_valid = 1'b0; bus.data = '0; bus.result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Gapless: all-ones params, 1..8 -> 36; then the mixed set -> 12.
    load(p_ones, 1'b0, 1'b1);
    run(v_seq, 1'b0, 1'b0, 36.0);
    load(p_set2, 1'b0, 1'b0);
    run(v_set2, 1'b0, 1'b0, 12.0);

    // Same vectors with 1-3 cycle gaps on data_valid.
    load(p_ones, 1'b1, 1'b0);
    run(v_seq, 1'b1, 1'b0, 36.0);
    load(p_set2, 1'b1, 1'b0);
    run(v_set2, 1'b1, 1'b0, 12.0);

    // Result held back for 10 cycles: 0.5+2+6+0+5+6+7+8 = 34.5.
    run(v_seq, 1'b0, 1'b1, 34.5);

    // Reset after three value beats, then reload and rerun.
    send_cmd(CMD_RUN);
    for (int i = 0; i < 3; i++) send_beat(v_seq[i], 0);
    check("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(p_ones, 1'b0, 1'b1);
    run(v_set2, 1'b0, 1'b0, 13.0);
    run(v_seq, 1'b1, 1'b0, 36.0);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
